// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: polynomial select encoding, tap positions and the
// active-length mask used by the generator and its reload logic.
package prbs_pkg;

  typedef enum logic [2:0] {
    PRBS7  = 3'd0,
    PRBS9  = 3'd1,
    PRBS15 = 3'd2,
    PRBS23 = 3'd3,
    PRBS31 = 3'd4
  } poly_sel_e;

  localparam int unsigned PRBS7_N  = 7;
  localparam int unsigned PRBS7_T  = 6;
  localparam int unsigned PRBS9_N  = 9;
  localparam int unsigned PRBS9_T  = 5;
  localparam int unsigned PRBS15_N = 15;
  localparam int unsigned PRBS15_T = 14;
  localparam int unsigned PRBS23_N = 23;
  localparam int unsigned PRBS23_T = 18;
  localparam int unsigned PRBS31_N = 31;
  localparam int unsigned PRBS31_T = 28;

  // Unused select codes fold onto PRBS7.
  function automatic poly_sel_e decode_poly(input logic [2:0] sel);
    case (sel)
      3'd1:    return PRBS9;
      3'd2:    return PRBS15;
      3'd3:    return PRBS23;
      3'd4:    return PRBS31;
      default: return PRBS7;
    endcase
  endfunction

  function automatic logic [31:0] poly_mask(input poly_sel_e p);
    case (p)
      PRBS9:   return (32'd1 << PRBS9_N) - 32'd1;
      PRBS15:  return (32'd1 << PRBS15_N) - 32'd1;
      PRBS23:  return (32'd1 << PRBS23_N) - 32'd1;
      PRBS31:  return (32'd1 << PRBS31_N) - 32'd1;
      default: return (32'd1 << PRBS7_N) - 32'd1;
    endcase
  endfunction

endpackage

// File: rtl/prbs_rate_div.sv
// Bit-period divider: counts 0..div_lat, reloading the latched period only at
// terminal count or restart so a rate change never cuts a bit short.
module prbs_rate_div #(
  parameter int DIV_W = 16
) (
  input  logic             dac_clk,
  input  logic             reset_n,
  input  logic             run_i,
  input  logic             restart_i,
  input  logic [DIV_W-1:0] rate_div_i,
  output logic             tc_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] lat_q, lat_d;

  assign tc_o = run_i && (cnt_q == lat_q);

  always_comb begin
    cnt_d = cnt_q;
    lat_d = lat_q;
    if (restart_i || tc_o) begin
      cnt_d = '0;
      lat_d = rate_div_i;
    end else if (run_i) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge dac_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      lat_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      lat_q <= lat_d;
    end
  end

endmodule

// File: rtl/prbs_lfsr_gen.sv
// Rate-programmable Fibonacci PRBS source with seed load, polynomial switch,
// lock-up recovery, output inversion and a sequence-start marker.
module prbs_lfsr_gen
  import prbs_pkg::*;
#(
  parameter int LFSR_W = 31,
  parameter int DIV_W  = 16
) (
  input  logic              dac_clk,
  input  logic              reset_n,
  input  logic              prbs_run,
  input  logic [2:0]        prbs_poly_sel,
  input  logic [DIV_W-1:0]  prbs_rate_div,
  input  logic [LFSR_W-1:0] prbs_seed,
  input  logic              prbs_seed_load,
  input  logic              prbs_invert,
  output logic              lfsr_clk_enable,
  output logic              prbs_bit_out,
  output logic              prbs_seq_start,
  output logic [LFSR_W-1:0] lfsr_state_dbg
);

  localparam logic [LFSR_W-1:0] LFSR_RST = LFSR_W'(32'h7F);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [LFSR_W-1:0] ref_q, ref_d;
  poly_sel_e         poly_q, poly_d, poly_new;
  logic              en_q, en_d;
  logic              bit_q, bit_d;
  logic              seq_q, seq_d;

  logic [LFSR_W-1:0] mask_cur, mask_new, seed_m, seed_v, shifted;
  logic              fb, poly_change, restart, tc;

  assign poly_new    = decode_poly(prbs_poly_sel);
  assign poly_change = (poly_new != poly_q);
  assign restart     = prbs_seed_load | poly_change;
  assign mask_cur    = LFSR_W'(poly_mask(poly_q));
  assign mask_new    = LFSR_W'(poly_mask(poly_new));
  assign seed_m      = prbs_seed & mask_new;
  assign seed_v      = (seed_m == '0) ? mask_new : seed_m;

  always_comb begin
    case (poly_q)
      PRBS9:   fb = lfsr_q[PRBS9_N-1]  ^ lfsr_q[PRBS9_T-1];
      PRBS15:  fb = lfsr_q[PRBS15_N-1] ^ lfsr_q[PRBS15_T-1];
      PRBS23:  fb = lfsr_q[PRBS23_N-1] ^ lfsr_q[PRBS23_T-1];
      PRBS31:  fb = lfsr_q[PRBS31_N-1] ^ lfsr_q[PRBS31_T-1];
      default: fb = lfsr_q[PRBS7_N-1]  ^ lfsr_q[PRBS7_T-1];
    endcase
  end

  assign shifted = {lfsr_q[LFSR_W-2:0], fb} & mask_cur;

  prbs_rate_div #(.DIV_W(DIV_W)) u_rate_div (
    .dac_clk    (dac_clk),
    .reset_n    (reset_n),
    .run_i      (prbs_run),
    .restart_i  (restart),
    .rate_div_i (prbs_rate_div),
    .tc_o       (tc)
  );

  // Priority: seed load, then polynomial change, then shift at terminal count.
  always_comb begin
    lfsr_d = lfsr_q;
    ref_d  = ref_q;
    poly_d = poly_q;
    en_d   = 1'b0;
    bit_d  = bit_q;
    seq_d  = 1'b0;
    if (prbs_seed_load) begin
      lfsr_d = seed_v;
      ref_d  = seed_v;
      poly_d = poly_new;
    end else if (poly_change) begin
      lfsr_d = mask_new;
      ref_d  = mask_new;
      poly_d = poly_new;
    end else if (tc) begin
      if ((lfsr_q & mask_cur) == '0) begin
        lfsr_d = mask_cur;
      end else begin
        lfsr_d = shifted;
        en_d   = 1'b1;
        bit_d  = fb ^ prbs_invert;
        seq_d  = (shifted == ref_q);
      end
    end
  end

  always_ff @(posedge dac_clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= LFSR_RST;
      ref_q  <= LFSR_RST;
      poly_q <= PRBS7;
      en_q   <= 1'b0;
      bit_q  <= 1'b0;
      seq_q  <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      ref_q  <= ref_d;
      poly_q <= poly_d;
      en_q   <= en_d;
      bit_q  <= bit_d;
      seq_q  <= seq_d;
    end
  end

  assign lfsr_clk_enable = en_q;
  assign prbs_bit_out    = bit_q;
  assign prbs_seq_start  = seq_q;
  assign lfsr_state_dbg  = lfsr_q;

endmodule

// File: tb/tb_prbs_lfsr_gen.sv
// Scoreboard bench for prbs_lfsr_gen: an integer-arithmetic LFSR model
// queues expected bits/markers, popped on each observed enable.
module tb_prbs_lfsr_gen;

  localparam int LFSR_W = 31;
  localparam int DIV_W  = 16;
  localparam int BUD    = 300;

  logic              dac_clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              prbs_run = 1'b0;
  logic [2:0]        prbs_poly_sel = 3'd0;
  logic [DIV_W-1:0]  prbs_rate_div = '0;
  logic [LFSR_W-1:0] prbs_seed = '0;
  logic              prbs_seed_load = 1'b0;
  logic              prbs_invert = 1'b0;
  logic              lfsr_clk_enable;
  logic              prbs_bit_out;
  logic              prbs_seq_start;
  logic [LFSR_W-1:0] lfsr_state_dbg;

  prbs_lfsr_gen #(.LFSR_W(LFSR_W), .DIV_W(DIV_W)) dut (
    .dac_clk         (dac_clk),
    .reset_n         (reset_n),
    .prbs_run        (prbs_run),
    .prbs_poly_sel   (prbs_poly_sel),
    .prbs_rate_div   (prbs_rate_div),
    .prbs_seed       (prbs_seed),
    .prbs_seed_load  (prbs_seed_load),
    .prbs_invert     (prbs_invert),
    .lfsr_clk_enable (lfsr_clk_enable),
    .prbs_bit_out    (prbs_bit_out),
    .prbs_seq_start  (prbs_seq_start),
    .lfsr_state_dbg  (lfsr_state_dbg)
  );

  always #5 dac_clk = ~dac_clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed { logic b; logic s; } exp_t;
  exp_t sb_q[$];

  logic [31:0] m_state, m_ref;
  int          m_n, m_t;
  logic        m_inv = 1'b0;

  task automatic model_load(input int n, input int t, input logic [31:0] v);
    m_n = n; m_t = t; m_state = v; m_ref = v;
  endtask

  task automatic push_expected(input int k);
    for (int i = 0; i < k; i++) begin
      logic [31:0] f, nx;
      exp_t e;
      f  = ((m_state >> (m_n - 1)) ^ (m_state >> (m_t - 1))) & 32'd1;
      nx = ((m_state << 1) | f) & ((32'd1 << m_n) - 32'd1);
      e.b = f[0] ^ m_inv;
      e.s = (nx == m_ref);
      m_state = nx;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_en(output int cyc);
    cyc = 0;
    do begin
      @(negedge dac_clk);
      cyc++;
    end while (lfsr_clk_enable !== 1'b1 && cyc < BUD);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge dac_clk);
    total++; if (lfsr_clk_enable !== 1'b0) begin bad++; $display("FAIL rst_en got=%b want=0", lfsr_clk_enable); end
    total++; if (prbs_bit_out !== 1'b0) begin bad++; $display("FAIL rst_bit got=%b want=0", prbs_bit_out); end
    total++; if (prbs_seq_start !== 1'b0) begin bad++; $display("FAIL rst_seq got=%b want=0", prbs_seq_start); end
    total++; if (lfsr_state_dbg !== 31'h7F) begin bad++; $display("FAIL rst_dbg got=%h want=7f", lfsr_state_dbg); end
  endtask

  task automatic test_prbs7();
    int cyc, ones, seq_cnt, first_seq;
    logic [6:0] first7;
    exp_t e;
    ones = 0; seq_cnt = 0; first_seq = -1; first7 = '0;
    model_load(7, 6, 32'h7F); m_inv = 1'b0;
    push_expected(254);
    prbs_rate_div = 16'd63; prbs_run = 1'b1; reset_n = 1'b1;
    wait_en(cyc);
    total++; if (cyc !== 1) begin bad++; $display("FAIL p7_first_gap got=%0d want=1", cyc); end
    for (int i = 0; i < 254; i++) begin
      if (i > 0) begin
        wait_en(cyc);
        total++; if (cyc !== 64) begin bad++; $display("FAIL p7_gap idx=%0d got=%0d want=64", i, cyc); end
      end
      e = sb_q.pop_front();
      total++; if (prbs_bit_out !== e.b) begin bad++; $display("FAIL p7_bit idx=%0d got=%b want=%b", i, prbs_bit_out, e.b); end
      total++; if (prbs_seq_start !== e.s) begin bad++; $display("FAIL p7_seq idx=%0d got=%b want=%b", i, prbs_seq_start, e.s); end
      if (i < 7) first7[6-i] = prbs_bit_out;
      if (i < 127 && prbs_bit_out === 1'b1) ones++;
      if (prbs_seq_start === 1'b1) begin
        seq_cnt++;
        if (first_seq < 0) first_seq = i;
      end
    end
    total++; if (first7 !== 7'b0000001) begin bad++; $display("FAIL p7_first7 got=%b want=0000001", first7); end
    total++; if (ones !== 64) begin bad++; $display("FAIL p7_ones got=%0d want=64", ones); end
    total++; if (first_seq !== 126) begin bad++; $display("FAIL p7_seq_pos got=%0d want=126", first_seq); end
    total++; if (seq_cnt !== 2) begin bad++; $display("FAIL p7_seq_cnt got=%0d want=2", seq_cnt); end
  endtask

  task automatic test_prbs9_full_rate();
    int not_en;
    exp_t e;
    not_en = 0;
    prbs_poly_sel = 3'd1; prbs_seed = 31'h1FF; prbs_rate_div = 16'd0; prbs_seed_load = 1'b1;
    @(negedge dac_clk);
    prbs_seed_load = 1'b0;
    total++; if (lfsr_clk_enable !== 1'b0) begin bad++; $display("FAIL p9_load_en got=%b want=0", lfsr_clk_enable); end
    total++; if (lfsr_state_dbg !== 31'h1FF) begin bad++; $display("FAIL p9_load_dbg got=%h want=1ff", lfsr_state_dbg); end
    model_load(9, 5, 32'h1FF);
    push_expected(511);
    for (int i = 0; i < 511; i++) begin
      @(negedge dac_clk);
      if (lfsr_clk_enable !== 1'b1) not_en++;
      e = sb_q.pop_front();
      total++; if (prbs_bit_out !== e.b) begin bad++; $display("FAIL p9_bit idx=%0d got=%b want=%b", i, prbs_bit_out, e.b); end
      total++; if (prbs_seq_start !== e.s) begin bad++; $display("FAIL p9_seq idx=%0d got=%b want=%b", i, prbs_seq_start, e.s); end
    end
    total++; if (lfsr_state_dbg !== 31'h1FF) begin bad++; $display("FAIL p9_wrap_dbg got=%h want=1ff", lfsr_state_dbg); end
    total++; if (not_en !== 0) begin bad++; $display("FAIL p9_en_held missing=%0d want=0", not_en); end
  endtask

  task automatic test_seed_zero();
    int cyc;
    exp_t e;
    prbs_poly_sel = 3'd2; prbs_seed = '0; prbs_rate_div = 16'd63; prbs_seed_load = 1'b1;
    @(negedge dac_clk);
    prbs_seed_load = 1'b0;
    total++; if (lfsr_clk_enable !== 1'b0) begin bad++; $display("FAIL sz_load_en got=%b want=0", lfsr_clk_enable); end
    total++; if (lfsr_state_dbg !== 31'h7FFF) begin bad++; $display("FAIL sz_dbg got=%h want=7fff", lfsr_state_dbg); end
    model_load(15, 14, 32'h7FFF);
    push_expected(1);
    wait_en(cyc);
    total++; if (cyc !== 64) begin bad++; $display("FAIL sz_gap got=%0d want=64", cyc); end
    e = sb_q.pop_front();
    total++; if (prbs_bit_out !== e.b) begin bad++; $display("FAIL sz_bit got=%b want=%b", prbs_bit_out, e.b); end
  endtask

  task automatic test_rate_change();
    int cyc;
    exp_t e;
    repeat (10) @(negedge dac_clk);
    prbs_rate_div = 16'd7;
    push_expected(4);
    for (int i = 0; i < 4; i++) begin
      wait_en(cyc);
      total++; if (cyc !== ((i == 0) ? 54 : 8)) begin bad++; $display("FAIL rc_gap idx=%0d got=%0d want=%0d", i, cyc, (i == 0) ? 54 : 8); end
      e = sb_q.pop_front();
      total++; if (prbs_bit_out !== e.b) begin bad++; $display("FAIL rc_bit idx=%0d got=%b want=%b", i, prbs_bit_out, e.b); end
    end
  endtask

  task automatic test_pause();
    int cyc, moved;
    logic hold_bit;
    logic [LFSR_W-1:0] hold_dbg;
    exp_t e;
    moved = 0;
    repeat (3) @(negedge dac_clk);
    prbs_run = 1'b0;
    hold_bit = prbs_bit_out; hold_dbg = lfsr_state_dbg;
    repeat (100) begin
      @(negedge dac_clk);
      if (lfsr_clk_enable !== 1'b0 || prbs_bit_out !== hold_bit || lfsr_state_dbg !== hold_dbg) moved++;
    end
    total++; if (moved !== 0) begin bad++; $display("FAIL pause_hold changed=%0d want=0", moved); end
    prbs_run = 1'b1;
    push_expected(1);
    wait_en(cyc);
    total++; if (cyc !== 5) begin bad++; $display("FAIL pause_resume_gap got=%0d want=5", cyc); end
    e = sb_q.pop_front();
    total++; if (prbs_bit_out !== e.b) begin bad++; $display("FAIL pause_bit got=%b want=%b", prbs_bit_out, e.b); end
  endtask

  task automatic test_invert();
    int cyc, ones;
    logic cap0 [127];
    logic hold_bit;
    exp_t e;
    ones = 0;
    for (int pass = 0; pass < 2; pass++) begin
      prbs_poly_sel = 3'd0; prbs_seed = 31'h7F; prbs_rate_div = 16'd0;
      prbs_invert = (pass == 1); prbs_seed_load = 1'b1;
      @(negedge dac_clk);
      prbs_seed_load = 1'b0;
      model_load(7, 6, 32'h7F); m_inv = (pass == 1);
      push_expected(127);
      for (int i = 0; i < 127; i++) begin
        @(negedge dac_clk);
        e = sb_q.pop_front();
        total++; if (prbs_bit_out !== e.b) begin bad++; $display("FAIL inv_bit pass=%0d idx=%0d got=%b want=%b", pass, i, prbs_bit_out, e.b); end
        if (pass == 0) cap0[i] = prbs_bit_out;
        else begin
          total++; if (prbs_bit_out !== ~cap0[i]) begin bad++; $display("FAIL inv_compl idx=%0d got=%b want=%b", i, prbs_bit_out, ~cap0[i]); end
          if (prbs_bit_out === 1'b1) ones++;
        end
      end
    end
    total++; if (ones !== 63) begin bad++; $display("FAIL inv_ones got=%0d want=63", ones); end
    prbs_rate_div = 16'd7;
    push_expected(1);
    wait_en(cyc);
    total++; if (cyc !== 1) begin bad++; $display("FAIL inv_gap got=%0d want=1", cyc); end
    e = sb_q.pop_front();
    total++; if (prbs_bit_out !== e.b) begin bad++; $display("FAIL inv_bit2 got=%b want=%b", prbs_bit_out, e.b); end
    hold_bit = prbs_bit_out;
    @(negedge dac_clk);
    prbs_invert = 1'b0;
    @(negedge dac_clk);
    total++; if (prbs_bit_out !== hold_bit) begin bad++; $display("FAIL inv_midbit got=%b want=%b", prbs_bit_out, hold_bit); end
    m_inv = 1'b0;
    push_expected(1);
    wait_en(cyc);
    total++; if (cyc !== 6) begin bad++; $display("FAIL inv_gap2 got=%0d want=6", cyc); end
    e = sb_q.pop_front();
    total++; if (prbs_bit_out !== e.b) begin bad++; $display("FAIL inv_bit3 got=%b want=%b", prbs_bit_out, e.b); end
  endtask

  task automatic test_load_vs_tc();
    int cyc;
    exp_t e;
    repeat (7) @(negedge dac_clk);
    prbs_seed = 31'h55; prbs_seed_load = 1'b1;
    @(negedge dac_clk);
    prbs_seed_load = 1'b0;
    total++; if (lfsr_clk_enable !== 1'b0) begin bad++; $display("FAIL ltc_en got=%b want=0", lfsr_clk_enable); end
    total++; if (lfsr_state_dbg !== 31'h55) begin bad++; $display("FAIL ltc_dbg got=%h want=55", lfsr_state_dbg); end
    model_load(7, 6, 32'h55);
    push_expected(1);
    wait_en(cyc);
    total++; if (cyc !== 8) begin bad++; $display("FAIL ltc_gap got=%0d want=8", cyc); end
    e = sb_q.pop_front();
    total++; if (prbs_bit_out !== e.b) begin bad++; $display("FAIL ltc_bit got=%b want=%b", prbs_bit_out, e.b); end
  endtask

  task automatic test_mid_reset();
    int en_seen;
    en_seen = 0;
    prbs_rate_div = 16'd0;
    repeat (5) @(negedge dac_clk);
    #2 reset_n = 1'b0;
    #1;
    total++; if (lfsr_state_dbg !== 31'h7F) begin bad++; $display("FAIL mr_dbg got=%h want=7f", lfsr_state_dbg); end
    total++; if (lfsr_clk_enable !== 1'b0) begin bad++; $display("FAIL mr_en got=%b want=0", lfsr_clk_enable); end
    total++; if (prbs_bit_out !== 1'b0) begin bad++; $display("FAIL mr_bit got=%b want=0", prbs_bit_out); end
    repeat (3) begin
      @(negedge dac_clk);
      if (lfsr_clk_enable !== 1'b0) en_seen++;
    end
    total++; if (en_seen !== 0) begin bad++; $display("FAIL mr_en_hold got=%0d want=0", en_seen); end
    prbs_run = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_prbs7();
    test_prbs9_full_rate();
    test_seed_zero();
    test_rate_change();
    test_pause();
    test_invert();
    test_load_vs_tc();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
